// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the two-requester burst ROM arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker. On a tie the requester that did not win the
// previous grant is chosen. The pointer comes out of reset as "requester 1
// won last", so requester 0 takes the first tie.
module mem_arb_rr (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic pick
);

  logic last_r;

  // Winner selection: alternate on ties, otherwise the lone requester.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last_r;
    end else if (req1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
  end

  // Last-grant pointer, advanced only when the arbiter accepts a burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (accept) begin
      last_r <= pick;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester burst arbiter in front of a pipelined ROM.
// A granted burst issues len+1 consecutive ROM reads, then waits in DRAIN
// until the last word has come back. Return data is steered to its owner by
// a READ_LAT-deep valid/owner/last pipeline.
// Optional build macro MEM_ARB_OUTREG_EN: adds one register stage on
// rdata/rvalid/rlast and lengthens DRAIN by one cycle to match.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [LEN_W-1:0]  len0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic              rlast0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic              rlast1,
  output logic [DATA_W-1:0] rdata,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta
);

`ifdef MEM_ARB_OUTREG_EN
  localparam int DRAIN_CYC = READ_LAT + 1;
`else
  localparam int DRAIN_CYC = READ_LAT;
`endif

  arb_state_e        state_r;
  logic              gnt0_r, gnt1_r, ena_r, owner_r;
  logic [ADDR_W-1:0] addra_r;
  logic [LEN_W-1:0]  len_r, idx_r;
  logic [2:0]        drain_r;
  logic              accept_s, pick_s;

  logic [READ_LAT-1:0] vld_sr_r, own_sr_r, last_sr_r;
  logic                tail_v_s, tail_o_s, tail_l_s;

  assign accept_s = (state_r == IDLE) && (req0 || req1);

  mem_arb_rr u_rr (
    .clk    (clka),
    .rst_n  (rsta_n),
    .req0   (req0),
    .req1   (req1),
    .accept (accept_s),
    .pick   (pick_s)
  );

  // Burst FSM: grant from IDLE, walk the address in BURST, wait out the ROM in DRAIN.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_r <= IDLE;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      ena_r   <= 1'b0;
      owner_r <= 1'b0;
      addra_r <= {ADDR_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      idx_r   <= {LEN_W{1'b0}};
      drain_r <= 3'd0;
    end else begin
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= BURST;
            owner_r <= pick_s;
            gnt0_r  <= ~pick_s;
            gnt1_r  <= pick_s;
            addra_r <= pick_s ? addr1 : addr0;
            len_r   <= pick_s ? len1 : len0;
            idx_r   <= {LEN_W{1'b0}};
            ena_r   <= 1'b1;
          end else begin
            ena_r   <= 1'b0;
          end
        end
        BURST: begin
          if (idx_r == len_r) begin
            // Last read issued; addra keeps this final address while idle.
            ena_r   <= 1'b0;
            state_r <= DRAIN;
            drain_r <= 3'(DRAIN_CYC - 1);
          end else begin
            idx_r   <= idx_r + LEN_W'(1);
            addra_r <= addra_r + ADDR_W'(1);
          end
        end
        DRAIN: begin
          ena_r <= 1'b0;
          if (drain_r == 3'd0) begin
            state_r <= IDLE;
          end else begin
            drain_r <= drain_r - 3'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          ena_r   <= 1'b0;
        end
      endcase
    end
  end

  // Read-return tag pipeline: one entry per ROM cycle, aligned to douta.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      vld_sr_r  <= {READ_LAT{1'b0}};
      own_sr_r  <= {READ_LAT{1'b0}};
      last_sr_r <= {READ_LAT{1'b0}};
    end else begin
      vld_sr_r[0]  <= (state_r == BURST);
      own_sr_r[0]  <= owner_r;
      last_sr_r[0] <= (idx_r == len_r);
      for (int i = 1; i < READ_LAT; i++) begin
        vld_sr_r[i]  <= vld_sr_r[i-1];
        own_sr_r[i]  <= own_sr_r[i-1];
        last_sr_r[i] <= last_sr_r[i-1];
      end
    end
  end

  assign tail_v_s = vld_sr_r[READ_LAT-1];
  assign tail_o_s = own_sr_r[READ_LAT-1];
  assign tail_l_s = last_sr_r[READ_LAT-1];

`ifdef MEM_ARB_OUTREG_EN
  logic              rvalid0_r, rvalid1_r, rlast0_r, rlast1_r;
  logic [DATA_W-1:0] rdata_r;

  // Extra output stage: capture the steered word one cycle after douta.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rlast0_r  <= 1'b0;
      rlast1_r  <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
    end else begin
      rvalid0_r <= tail_v_s & ~tail_o_s;
      rvalid1_r <= tail_v_s &  tail_o_s;
      rlast0_r  <= tail_v_s & ~tail_o_s & tail_l_s;
      rlast1_r  <= tail_v_s &  tail_o_s & tail_l_s;
      rdata_r   <= tail_v_s ? douta : {DATA_W{1'b0}};
    end
  end

  assign rvalid0 = rvalid0_r;
  assign rvalid1 = rvalid1_r;
  assign rlast0  = rlast0_r;
  assign rlast1  = rlast1_r;
  assign rdata   = rdata_r;
`else
  logic [DATA_W-1:0] rdata_s;

  // Direct return path: zero the shared bus whenever no word is valid.
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    if (tail_v_s) begin
      rdata_s = douta;
    end else begin
      rdata_s = {DATA_W{1'b0}};
    end
  end

  assign rvalid0 = tail_v_s & ~tail_o_s;
  assign rvalid1 = tail_v_s &  tail_o_s;
  assign rlast0  = tail_v_s & ~tail_o_s & tail_l_s;
  assign rlast1  = tail_v_s &  tail_o_s & tail_l_s;
  assign rdata   = rdata_s;
`endif

  assign gnt0  = gnt0_r;
  assign gnt1  = gnt1_r;
  assign ena   = ena_r;
  assign addra = addra_r;

endmodule
